// File: rtl/fregs_wb_arbiter.sv
// Write-back arbiter for the FP register file's single write port: three one-entry request
// buffers, round-robin grant, and a pending-write scoreboard. Optional macro: FREGS_WB_DBG_PRIO_EN.
module fregs_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iFpuValid,
    input  logic [ADDR_W-1:0] iFpuRd,
    input  logic [DATA_W-1:0] iFpuData,
    output logic              oFpuReady,
    input  logic              iLdValid,
    input  logic [ADDR_W-1:0] iLdRd,
    input  logic [DATA_W-1:0] iLdData,
    output logic              oLdReady,
    input  logic              iDbgValid,
    input  logic [ADDR_W-1:0] iDbgRd,
    input  logic [DATA_W-1:0] iDbgData,
    output logic              oDbgReady,
    input  logic              iIssueValid,
    input  logic [ADDR_W-1:0] iIssueRd,
    input  logic [ADDR_W-1:0] iQueryRs1,
    input  logic [ADDR_W-1:0] iQueryRs2,
    input  logic [ADDR_W-1:0] iQueryRs3,
    output logic              oRs1Busy,
    output logic              oRs2Busy,
    output logic              oRs3Busy,
    output logic              oRegWrite,
    output logic [ADDR_W-1:0] oWriteRegister,
    output logic [DATA_W-1:0] oWriteData,
    output logic [2:0]        oGrant
);
    localparam int NREG = 1 << ADDR_W;

    // Handshake: a requester transfers {rd, data} on a posedge where valid && ready;
    // ready is simply "buffer empty", a registered signal with no path from any valid.
    logic [2:0]        buf_full;
    logic [ADDR_W-1:0] buf_rd   [3];
    logic [DATA_W-1:0] buf_data [3];
    logic [2:0]        in_valid;
    logic [ADDR_W-1:0] in_rd    [3];
    logic [DATA_W-1:0] in_data  [3];
    logic [1:0]        last_grant;
    logic [NREG-1:0]   pending;
    logic [1:0]        win_idx;
    logic              win_any;
    logic [1:0]        ord0, ord1, ord2;
    logic              clr_en;
    logic [ADDR_W-1:0] clr_rd;
    logic              waw_hazard;

    assign in_valid   = {iDbgValid, iLdValid, iFpuValid};
    assign in_rd[0]   = iFpuRd;
    assign in_rd[1]   = iLdRd;
    assign in_rd[2]   = iDbgRd;
    assign in_data[0] = iFpuData;
    assign in_data[1] = iLdData;
    assign in_data[2] = iDbgData;

    assign oFpuReady = ~buf_full[0];
    assign oLdReady  = ~buf_full[1];
    assign oDbgReady = ~buf_full[2];

    // Search order starts one above the last granted requester.
    always_comb begin
        ord0 = 2'd0;
        ord1 = 2'd1;
        ord2 = 2'd2;
`ifdef FREGS_WB_DBG_PRIO_EN
        ord0 = 2'd2;
        if (last_grant == 2'd0) begin
            ord1 = 2'd1;
            ord2 = 2'd0;
        end else begin
            ord1 = 2'd0;
            ord2 = 2'd1;
        end
`else
        case (last_grant)
            2'd0: begin ord0 = 2'd1; ord1 = 2'd2; ord2 = 2'd0; end
            2'd1: begin ord0 = 2'd2; ord1 = 2'd0; ord2 = 2'd1; end
            default: begin ord0 = 2'd0; ord1 = 2'd1; ord2 = 2'd2; end
        endcase
`endif
    end

    always_comb begin
        win_idx = 2'd0;
        win_any = 1'b0;
        if (buf_full[ord0]) begin
            win_idx = ord0;
            win_any = 1'b1;
        end else if (buf_full[ord1]) begin
            win_idx = ord1;
            win_any = 1'b1;
        end else if (buf_full[ord2]) begin
            win_idx = ord2;
            win_any = 1'b1;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            buf_full       <= '0;
            last_grant     <= 2'd2;
            oRegWrite      <= 1'b0;
            oWriteRegister <= '0;
            oWriteData     <= '0;
            oGrant         <= '0;
            for (int i = 0; i < 3; i++) begin
                buf_rd[i]   <= '0;
                buf_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (in_valid[i] && !buf_full[i]) begin
                    buf_full[i] <= 1'b1;
                    buf_rd[i]   <= in_rd[i];
                    buf_data[i] <= in_data[i];
                end
            end
            // The winner is full, so it cannot also be accepting on this edge.
            if (win_any) begin
                buf_full[win_idx] <= 1'b0;
                oRegWrite         <= 1'b1;
                oWriteRegister    <= buf_rd[win_idx];
                oWriteData        <= buf_data[win_idx];
                oGrant            <= 3'b001 << win_idx;
`ifdef FREGS_WB_DBG_PRIO_EN
                if (win_idx != 2'd2) last_grant <= win_idx;
`else
                last_grant <= win_idx;
`endif
            end else begin
                oRegWrite <= 1'b0;
                oGrant    <= '0;
            end
        end
    end

    // Debug writes bypass the scoreboard; a same-edge issue of the cleared index wins.
    assign clr_en = win_any && (win_idx != 2'd2);
    assign clr_rd = buf_rd[win_idx];

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            pending <= '0;
        end else begin
            if (clr_en) pending[clr_rd] <= 1'b0;
            if (iIssueValid) pending[iIssueRd] <= 1'b1;
        end
    end

    assign oRs1Busy = pending[iQueryRs1];
    assign oRs2Busy = pending[iQueryRs2];
    assign oRs3Busy = pending[iQueryRs3];

    // A second issue to a pending rd is a WAW protocol error unless that write retires now.
    assign waw_hazard = iIssueValid && pending[iIssueRd] && !(clr_en && (clr_rd == iIssueRd));

    waw_issue_check: assert property (@(posedge iCLK) disable iff (!iRST_N) !waw_hazard);

endmodule

// File: tb/tb_fregs_wb_arbiter.sv
// Self-checking bench for fregs_wb_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level reference model of buffers, rotation and scoreboard.
module tb_fregs_wb_arbiter;
    logic        iCLK = 1'b0;
    logic        iRST_N = 1'b0;
    logic        iFpuValid = 1'b0, iLdValid = 1'b0, iDbgValid = 1'b0;
    logic [4:0]  iFpuRd = '0, iLdRd = '0, iDbgRd = '0;
    logic [31:0] iFpuData = '0, iLdData = '0, iDbgData = '0;
    logic        oFpuReady, oLdReady, oDbgReady;
    logic        iIssueValid = 1'b0;
    logic [4:0]  iIssueRd = '0;
    logic [4:0]  iQueryRs1 = '0, iQueryRs2 = '0, iQueryRs3 = '0;
    logic        oRs1Busy, oRs2Busy, oRs3Busy;
    logic        oRegWrite;
    logic [4:0]  oWriteRegister;
    logic [31:0] oWriteData;
    logic [2:0]  oGrant;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Reference model state
    bit          m_full [3];
    logic [4:0]  m_rd   [3];
    logic [31:0] m_data [3];
    int          m_last;
    bit          m_pend [32];
    logic        m_we;
    logic [4:0]  m_wr;
    logic [31:0] m_wd;
    logic [2:0]  m_gnt;

    logic [39:0] exp_q [$];

    fregs_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N),
        .iFpuValid(iFpuValid), .iFpuRd(iFpuRd), .iFpuData(iFpuData), .oFpuReady(oFpuReady),
        .iLdValid(iLdValid), .iLdRd(iLdRd), .iLdData(iLdData), .oLdReady(oLdReady),
        .iDbgValid(iDbgValid), .iDbgRd(iDbgRd), .iDbgData(iDbgData), .oDbgReady(oDbgReady),
        .iIssueValid(iIssueValid), .iIssueRd(iIssueRd),
        .iQueryRs1(iQueryRs1), .iQueryRs2(iQueryRs2), .iQueryRs3(iQueryRs3),
        .oRs1Busy(oRs1Busy), .oRs2Busy(oRs2Busy), .oRs3Busy(oRs3Busy),
        .oRegWrite(oRegWrite), .oWriteRegister(oWriteRegister),
        .oWriteData(oWriteData), .oGrant(oGrant)
    );

    always #5 iCLK = ~iCLK;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_full[i] = 0;
            m_rd[i]   = '0;
            m_data[i] = '0;
        end
        for (int i = 0; i < 32; i++) m_pend[i] = 0;
        m_last = 2;
        m_we = 0; m_wr = '0; m_wd = '0; m_gnt = '0;
    endtask

    task automatic idle_inputs();
        iFpuValid = 0; iLdValid = 0; iDbgValid = 0; iIssueValid = 0;
    endtask

    // Advance one clock: predict the edge from the current inputs, then let the DUT take it.
    task automatic step();
        bit          v [3];
        logic [4:0]  r [3];
        logic [31:0] d [3];
        bit          old_full [3];
        int          w;
        v[0] = iFpuValid; v[1] = iLdValid; v[2] = iDbgValid;
        r[0] = iFpuRd;    r[1] = iLdRd;    r[2] = iDbgRd;
        d[0] = iFpuData;  d[1] = iLdData;  d[2] = iDbgData;
        old_full = m_full;
        w = -1;
`ifdef FREGS_WB_DBG_PRIO_EN
        if (m_full[2]) w = 2;
        else begin
            int first;
            first = (m_last == 0) ? 1 : 0;
            if (m_full[first]) w = first;
            else if (m_full[1 - first]) w = 1 - first;
        end
`else
        for (int k = 1; k <= 3; k++)
            if (w < 0 && m_full[(m_last + k) % 3]) w = (m_last + k) % 3;
`endif
        if (w >= 0) begin
            m_we = 1; m_wr = m_rd[w]; m_wd = m_data[w]; m_gnt = 3'(1 << w);
            if (w != 2) m_pend[m_rd[w]] = 0;
            m_full[w] = 0;
`ifdef FREGS_WB_DBG_PRIO_EN
            if (w != 2) m_last = w;
`else
            m_last = w;
`endif
        end else begin
            m_we = 0; m_gnt = '0;
        end
        for (int i = 0; i < 3; i++)
            if (v[i] && !old_full[i]) begin
                m_full[i] = 1; m_rd[i] = r[i]; m_data[i] = d[i];
            end
        if (iIssueValid) m_pend[iIssueRd] = 1;
        @(posedge iCLK); #1;
        cyc++;
    endtask

    task automatic do_reset();
        idle_inputs();
        iRST_N = 0;
        model_reset();
        @(posedge iCLK); #1;
        @(posedge iCLK); #1;
        iRST_N = 1;
    endtask

    task automatic test_reset();
        do_reset();
        iQueryRs1 = 5'd0; iQueryRs2 = 5'd9; iQueryRs3 = 5'd31;
        #1;
        total++; if (oRegWrite !== 1'b0) begin bad++; $display("FAIL rst_we got=%b exp=0", oRegWrite); end
        total++; if (oWriteRegister !== 5'd0) begin bad++; $display("FAIL rst_wr got=%0d exp=0", oWriteRegister); end
        total++; if (oWriteData !== 32'd0) begin bad++; $display("FAIL rst_wd got=%h exp=0", oWriteData); end
        total++; if (oGrant !== 3'b000) begin bad++; $display("FAIL rst_gnt got=%b exp=000", oGrant); end
        total++; if ({oDbgReady, oLdReady, oFpuReady} !== 3'b111) begin
            bad++; $display("FAIL rst_ready got=%b exp=111", {oDbgReady, oLdReady, oFpuReady}); end
        total++; if ({oRs1Busy, oRs2Busy, oRs3Busy} !== 3'b000) begin
            bad++; $display("FAIL rst_busy got=%b exp=000", {oRs1Busy, oRs2Busy, oRs3Busy}); end
        // Fill all buffers, start one write, then reset asynchronously mid-transfer.
        iFpuValid = 1; iFpuRd = 5'd1; iFpuData = $urandom;
        iLdValid  = 1; iLdRd  = 5'd2; iLdData  = $urandom;
        iDbgValid = 1; iDbgRd = 5'd3; iDbgData = $urandom;
        iIssueValid = 1; iIssueRd = 5'd9;
        step();
        idle_inputs();
        step();
        #2;
        iRST_N = 0;
        model_reset();
        #1;
        total++; if (oRegWrite !== 1'b0) begin bad++; $display("FAIL midrst_we got=%b exp=0", oRegWrite); end
        total++; if (oGrant !== 3'b000) begin bad++; $display("FAIL midrst_gnt got=%b exp=000", oGrant); end
        total++; if ({oDbgReady, oLdReady, oFpuReady} !== 3'b111) begin
            bad++; $display("FAIL midrst_ready got=%b exp=111", {oDbgReady, oLdReady, oFpuReady}); end
        total++; if (oRs2Busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", oRs2Busy); end
        @(posedge iCLK); #1;
        iRST_N = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (oRegWrite !== 1'b0) begin
                bad++; $display("FAIL midrst_stale_write cyc=%0d got=%b exp=0", i, oRegWrite); end
        end
    endtask

    task automatic test_single();
        iLdValid = 1; iLdRd = 5'd5; iLdData = 32'h3F80_0000;
        step();
        iLdValid = 0;
        total++; if (oLdReady !== 1'b0) begin bad++; $display("FAIL single_ready_e0 got=%b exp=0", oLdReady); end
        total++; if (oRegWrite !== 1'b0) begin bad++; $display("FAIL single_we_e0 got=%b exp=0", oRegWrite); end
        step();
        total++; if (oRegWrite !== 1'b1) begin bad++; $display("FAIL single_we got=%b exp=1", oRegWrite); end
        total++; if (oWriteRegister !== 5'd5) begin bad++; $display("FAIL single_wr got=%0d exp=5", oWriteRegister); end
        total++; if (oWriteData !== 32'h3F80_0000) begin bad++; $display("FAIL single_wd got=%h exp=3f800000", oWriteData); end
        total++; if (oGrant !== 3'b010) begin bad++; $display("FAIL single_gnt got=%b exp=010", oGrant); end
        total++; if (oLdReady !== 1'b1) begin bad++; $display("FAIL single_ready_e1 got=%b exp=1", oLdReady); end
        step();
        total++; if (oRegWrite !== 1'b0) begin bad++; $display("FAIL single_we_e2 got=%b exp=0", oRegWrite); end
        total++; if (oGrant !== 3'b000) begin bad++; $display("FAIL single_gnt_e2 got=%b exp=000", oGrant); end
    endtask

    task automatic test_contention();
        logic [39:0] e;
        do_reset();
        for (int rep = 0; rep < 2; rep++) begin
            iFpuValid = 1; iFpuRd = 5'd1; iFpuData = 32'h0000_0100;
            iLdValid  = 1; iLdRd  = 5'd2; iLdData  = 32'h0000_0200;
            iDbgValid = 1; iDbgRd = 5'd3; iDbgData = 32'h0000_0300;
`ifdef FREGS_WB_DBG_PRIO_EN
            exp_q.push_back({3'b100, 5'd3, 32'h0000_0300});
            exp_q.push_back({3'b001, 5'd1, 32'h0000_0100});
            exp_q.push_back({3'b010, 5'd2, 32'h0000_0200});
`else
            exp_q.push_back({3'b001, 5'd1, 32'h0000_0100});
            exp_q.push_back({3'b010, 5'd2, 32'h0000_0200});
            exp_q.push_back({3'b100, 5'd3, 32'h0000_0300});
`endif
            step();
            idle_inputs();
            for (int i = 0; i < 3; i++) begin
                step();
                e = exp_q.pop_front();
                total++; if (oRegWrite !== 1'b1 || {oGrant, oWriteRegister, oWriteData} !== e) begin
                    bad++; $display("FAIL contend rep=%0d slot=%0d got=%b/%b/%0d/%h exp=1/%b/%0d/%h", rep, i,
                        oRegWrite, oGrant, oWriteRegister, oWriteData, e[39:37], e[36:32], e[31:0]);
                end
            end
            step();
            total++; if (oRegWrite !== 1'b0) begin bad++; $display("FAIL contend_idle rep=%0d got=%b exp=0", rep, oRegWrite); end
        end
    endtask

    task automatic test_scoreboard();
        iIssueValid = 1; iIssueRd = 5'd7;
        step();
        iIssueValid = 0;
        iQueryRs1 = 5'd7; iQueryRs2 = 5'd7; iQueryRs3 = 5'd8;
        #1;
        total++; if ({oRs1Busy, oRs2Busy, oRs3Busy} !== 3'b110) begin
            bad++; $display("FAIL sb_issue got=%b exp=110", {oRs1Busy, oRs2Busy, oRs3Busy}); end
        iFpuValid = 1; iFpuRd = 5'd7; iFpuData = $urandom;
        step();
        iFpuValid = 0;
        total++; if (oRs1Busy !== 1'b1) begin bad++; $display("FAIL sb_buffered got=%b exp=1", oRs1Busy); end
        step();
        total++; if (oGrant !== 3'b001) begin bad++; $display("FAIL sb_grant got=%b exp=001", oGrant); end
        total++; if (oRs1Busy !== 1'b0) begin bad++; $display("FAIL sb_cleared got=%b exp=0", oRs1Busy); end
    endtask

    task automatic test_collision();
        iIssueValid = 1; iIssueRd = 5'd7;
        step();
        iIssueValid = 0;
        iFpuValid = 1; iFpuRd = 5'd7; iFpuData = $urandom;
        step();
        iFpuValid = 0;
        iIssueValid = 1; iIssueRd = 5'd7;
        step();
        iIssueValid = 0;
        total++; if (oGrant !== 3'b001 || oWriteRegister !== 5'd7) begin
            bad++; $display("FAIL coll_grant got=%b/%0d exp=001/7", oGrant, oWriteRegister); end
        total++; if (oRs1Busy !== 1'b1) begin bad++; $display("FAIL coll_set_wins got=%b exp=1", oRs1Busy); end
        iDbgValid = 1; iDbgRd = 5'd7; iDbgData = $urandom;
        step();
        iDbgValid = 0;
        step();
        total++; if (oGrant !== 3'b100) begin bad++; $display("FAIL coll_dbg_grant got=%b exp=100", oGrant); end
        total++; if (oRs1Busy !== 1'b1) begin bad++; $display("FAIL coll_dbg_keeps got=%b exp=1", oRs1Busy); end
        iFpuValid = 1; iFpuRd = 5'd7; iFpuData = $urandom;
        step();
        iFpuValid = 0;
        step();
        total++; if (oRs1Busy !== 1'b0) begin bad++; $display("FAIL coll_final_clear got=%b exp=0", oRs1Busy); end
    endtask

    task automatic test_random();
        logic [4:0] ir;
        for (int n = 0; n < 600; n++) begin
            iFpuValid = ($urandom_range(0, 9) < 6); iFpuRd = 5'($urandom); iFpuData = $urandom;
            iLdValid  = ($urandom_range(0, 9) < 6); iLdRd  = 5'($urandom); iLdData  = $urandom;
            iDbgValid = ($urandom_range(0, 9) < 4); iDbgRd = 5'($urandom); iDbgData = $urandom;
            ir = 5'($urandom);
            iIssueRd = ir;
            iIssueValid = ($urandom_range(0, 9) < 4) && !m_pend[ir];
            iQueryRs1 = 5'($urandom); iQueryRs2 = 5'($urandom); iQueryRs3 = 5'($urandom);
            step();
            total++; if (oRegWrite !== m_we || oGrant !== m_gnt) begin
                bad++; $display("FAIL rand_grant cyc=%0d got=%b/%b exp=%b/%b", cyc, oRegWrite, oGrant, m_we, m_gnt); end
            if (m_we) begin
                total++; if (oWriteRegister !== m_wr || oWriteData !== m_wd) begin
                    bad++; $display("FAIL rand_wdata cyc=%0d got=%0d/%h exp=%0d/%h", cyc, oWriteRegister, oWriteData, m_wr, m_wd); end
            end
            total++; if ({oDbgReady, oLdReady, oFpuReady} !== {!m_full[2], !m_full[1], !m_full[0]}) begin
                bad++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, {oDbgReady, oLdReady, oFpuReady},
                    {!m_full[2], !m_full[1], !m_full[0]}); end
            total++; if ({oRs1Busy, oRs2Busy, oRs3Busy} !== {m_pend[iQueryRs1], m_pend[iQueryRs2], m_pend[iQueryRs3]}) begin
                bad++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", cyc, {oRs1Busy, oRs2Busy, oRs3Busy},
                    {m_pend[iQueryRs1], m_pend[iQueryRs2], m_pend[iQueryRs3]}); end
        end
        idle_inputs();
        for (int i = 0; i < 4; i++) step();
    endtask

`ifdef FREGS_WB_DBG_PRIO_EN
    task automatic test_dbg_prio();
        bit dbg_full_before;
        iDbgValid = 1; iFpuValid = 1;
        for (int n = 0; n < 24; n++) begin
            iDbgRd = 5'($urandom); iDbgData = $urandom;
            iFpuRd = 5'($urandom); iFpuData = $urandom;
            dbg_full_before = m_full[2];
            step();
            if (dbg_full_before) begin
                total++; if (oGrant !== 3'b100) begin
                    bad++; $display("FAIL dbg_prio cyc=%0d got=%b exp=100", cyc, oGrant); end
            end else begin
                total++; if (oGrant === 3'b100) begin
                    bad++; $display("FAIL dbg_empty cyc=%0d got=%b exp=not100", cyc, oGrant); end
            end
        end
        idle_inputs();
        for (int i = 0; i < 4; i++) step();
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_contention();
        test_scoreboard();
        test_collision();
        test_random();
`ifdef FREGS_WB_DBG_PRIO_EN
        test_dbg_prio();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
